// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, data width and the baud-rate
// helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Rounded to nearest, so 10 MHz / 19200 baud yields 521.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. It is generic in
// width and depth so the receive path can reuse it.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: storage has no reset; an empty count already makes stale words invisible.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: registers use <= so every one of them samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes in a small FIFO and sends 8N1 frames (optional
// parity). tx_out and tx_done are registered from the current state, one cycle behind it.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] tx_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int              CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic            ODD_BIT    = (PARITY_ODD != 0);
  localparam int              FCNT_W     = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       r_state;
  uart_state_e       w_next_state;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shreg;
  logic              r_parity;
  logic              r_tx_out;
  logic              r_done;

  logic [7:0]        w_head;
  logic              w_full;
  logic              w_empty;
  logic [FCNT_W-1:0] w_count;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_tx_out_next;
  logic              w_done_next;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (tx_clk),
    .i_rst   (rst),
    .i_push  (tx_valid),
    .i_data  (tx_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_bit_end = (r_clk_cnt == LAST_CNT);
  assign tx_ready  = !w_full;
  assign tx_busy   = (r_state != IDLE) || (w_count != '0);
  assign tx_out    = r_tx_out;
  assign tx_done   = r_done;

  always_ff @(posedge tx_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_done_next   = 1'b0;
    w_tx_out_next = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        w_tx_out_next = 1'b0;
        if (w_bit_end) w_next_state = DATA;
      end
      DATA: begin
        w_tx_out_next = r_shreg[0];
        if (w_bit_end && r_bit_idx == LAST_BIT) begin
          if (PARITY_EN != 0) w_next_state = PARITY;
          else                w_next_state = STOP;
        end
      end
      PARITY: begin
        w_tx_out_next = r_parity;
        if (w_bit_end) w_next_state = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          w_done_next = 1'b1;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_tx_out  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_tx_out <= w_tx_out_next;
      r_done   <= w_done_next;
      if (w_pop) begin
        r_shreg   <= w_head;
        r_bit_idx <= '0;
        r_clk_cnt <= '0;
        // Taken from the popped byte; the shift register is consumed as bits go out.
        r_parity  <= (^w_head) ^ ODD_BIT;
      end else if (r_state != IDLE) begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
        if (r_state == DATA && w_bit_end) begin
          r_shreg   <= {1'b0, r_shreg[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven single frames, FIFO/back-to-back
// streams, reset mid-frame and a random loopback into a behavioural receiver.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int N_DUT = 4;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic [7:0] din  [N_DUT];
  logic       v    [N_DUT];
  logic       rdy  [N_DUT];
  logic       out  [N_DUT];
  logic       busy [N_DUT];
  logic       done [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_bytes[$];
  int         acc_q[$];
  int         done_q[$];
  logic       line_q[$];
  logic       rdy_q[$];
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  bit         rx_en   = 1'b0;

  always #5 tx_clk = ~tx_clk;

  // 0: no parity, 1: even parity, 2: odd parity, 3: loopback at 16 clocks/bit
  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .tx_clk(tx_clk), .rst(rst), .tx_in(din[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
    .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .tx_clk(tx_clk), .rst(rst), .tx_in(din[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
    .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .tx_clk(tx_clk), .rst(rst), .tx_in(din[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
    .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_lb (
    .tx_clk(tx_clk), .rst(rst), .tx_in(din[3]), .tx_valid(v[3]), .tx_ready(rdy[3]),
    .tx_out(out[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  // Line level for bit slot b of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int b,
                                     input logic pe, input logic po);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return (^d) ^ po;
    return 1'b1;
  endfunction

  // Streams tx_bytes into DUT s with tx_valid held while bytes remain, logging the line,
  // ready, accepts and done pulses. Sample i is taken just after edge i of the run.
  task automatic run_stream(input string tag, input int s, input int cpb,
                            input logic pe, input logic po);
    int n     = tx_bytes.size();
    int nbits = pe ? 11 : 10;
    int flen  = nbits * cpb;
    int total = 2 + n * flen + 4;
    int k     = 0;
    int errs  = 0;
    int derr  = 0;
    logic acc;
    acc_q.delete(); done_q.delete(); line_q.delete(); rdy_q.delete();
    for (int i = 0; i < total; i++) begin
      if (k < n) begin
        v[s]   = 1'b1;
        din[s] = tx_bytes[k];
      end else begin
        v[s] = 1'b0;
      end
      acc = v[s] && rdy[s];
      step();
      if (acc) begin
        acc_q.push_back(i);
        k++;
      end
      line_q.push_back(out[s]);
      rdy_q.push_back(rdy[s]);
      if (done[s]) done_q.push_back(i);
    end
    v[s] = 1'b0;
    for (int i = 0; i < total; i++) begin
      logic e;
      int   j;
      if (i < 2) begin
        e = 1'b1;
      end else begin
        j = (i - 2) / flen;
        e = (j < n) ? frame_bit(tx_bytes[j], ((i - 2) % flen) / cpb, pe, po) : 1'b1;
      end
      if (line_q[i] !== e) errs++;
    end
    check({tag, "_accepts"}, acc_q.size(), n);
    check({tag, "_first_accept"}, (acc_q.size() > 0) ? acc_q[0] : -1, 0);
    check({tag, "_wave_errs"}, errs, 0);
    check({tag, "_done_count"}, done_q.size(), n);
    for (int j = 0; j < done_q.size() && j < n; j++)
      if (done_q[j] != 2 + (j + 1) * flen - 1) derr++;
    check({tag, "_done_timing_errs"}, derr, 0);
    check({tag, "_idle_busy"}, busy[s], 1'b0);
    check({tag, "_idle_line"}, out[s], 1'b1);
  endtask

  // Behavioural receiver on the loopback line: mid-bit sampling, 16 clocks per bit.
  initial begin : rx_model
    logic [7:0] b;
    logic       st;
    b = '0;
    forever begin
      @(negedge out[3]);
      if (rx_en) begin
        repeat (8) @(negedge tx_clk);
        st = out[3];
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge tx_clk);
          b[k] = out[3];
        end
        repeat (16) @(negedge tx_clk);
        if (st !== 1'b0 || out[3] !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         nbits;
    logic [10:0] exp_bits;  // line level per bit slot, start bit in [0]
  } vec_t;

  initial begin : main
    vec_t       vecs[6];
    int         exp_acc6[6];
    logic [10:0] cap;
    int         errs;
    int         lows;
    int         dones;

    vecs[0] = '{0, 8'hA5, 10, 11'h34A};
    vecs[1] = '{1, 8'h07, 11, 11'h60E};
    vecs[2] = '{2, 8'h07, 11, 11'h40E};
    vecs[3] = '{1, 8'hFF, 11, 11'h5FE};
    vecs[4] = '{2, 8'h00, 11, 11'h600};
    vecs[5] = '{0, 8'h3C, 10, 11'h278};
    exp_acc6 = '{0, 1, 2, 3, 4, 42};

    for (int s = 0; s < N_DUT; s++) begin
      v[s]   = 1'b0;
      din[s] = 8'h00;
    end
    rst = 1'b1;
    repeat (2) step();
    for (int s = 0; s < N_DUT; s++) begin
      check($sformatf("reset_out_%0d", s),   out[s],  1'b1);
      check($sformatf("reset_ready_%0d", s), rdy[s],  1'b1);
      check($sformatf("reset_busy_%0d", s),  busy[s], 1'b0);
      check($sformatf("reset_done_%0d", s),  done[s], 1'b0);
    end
    rst = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      tx_bytes = {vecs[t].data};
      run_stream($sformatf("vec%0d", t), vecs[t].sel, 4,
                 vecs[t].sel != 0, vecs[t].sel == 2);
      cap = '0;
      for (int b = 0; b < vecs[t].nbits; b++) cap[b] = line_q[2 + b * 4 + 2];
      check($sformatf("vec%0d_bits", t), cap, vecs[t].exp_bits);
      check($sformatf("vec%0d_start_latency", t), {line_q[1], line_q[2]}, 2'b10);
      check($sformatf("vec%0d_frame_len", t),
            (done_q.size() > 0) ? done_q[0] - 1 : -1, vecs[t].nbits * 4);
      step();
    end

    tx_bytes = {8'h00, 8'hFF, 8'h3C, 8'h81};
    run_stream("b2b", 0, 4, 1'b0, 1'b0);
    errs = 0;
    for (int j = 0; j < 4; j++) if (j >= acc_q.size() || acc_q[j] != j) errs++;
    check("b2b_ready_all_cycles", errs, 0);
    step();

    tx_bytes = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run_stream("full", 0, 4, 1'b0, 1'b0);
    errs = 0;
    for (int j = 0; j < 6; j++) if (j >= acc_q.size() || acc_q[j] != exp_acc6[j]) errs++;
    check("full_accept_edges", errs, 0);
    check("full_ready_low_after_5", rdy_q[4], 1'b0);
    check("full_ready_back_after_pop", rdy_q[41], 1'b1);
    step();

    v[0] = 1'b1; din[0] = 8'h5A; step();
    din[0] = 8'h96; step();
    v[0] = 1'b0;
    repeat (18) step();
    check("pre_rst_line_data_bit3", out[0], 1'b1);
    check("pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1; v[0] = 1'b1; din[0] = 8'hFF;
    step();
    check("rst_line", out[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    rst = 1'b0; v[0] = 1'b0;
    lows = 0; dones = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (out[0] !== 1'b1) lows++;
      if (done[0] !== 1'b0) dones++;
    end
    check("post_rst_line_low_cycles", lows, 0);
    check("post_rst_done_pulses", dones, 0);
    check("post_rst_busy", busy[0], 1'b0);
    tx_bytes = {8'hC3};
    run_stream("after_rst", 0, 4, 1'b0, 1'b0);
    step();

    tx_bytes.delete();
    for (int j = 0; j < 256; j++) tx_bytes.push_back(8'($urandom_range(0, 255)));
    rx_en = 1'b1;
    run_stream("loop", 3, 16, 1'b0, 1'b0);
    rx_en = 1'b0;
    check("loop_rx_count", rx_q.size(), 256);
    check("loop_rx_frame_errs", rx_ferr, 0);
    for (int j = 0; j < rx_q.size() && j < 256; j++)
      check($sformatf("loop_byte_%0d", j), rx_q[j], tx_bytes[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
